// File: rtl/phy_tx_lanes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_lanes_pkg
//  Description : Shared constants and helpers for the multi-lane PHY
//                transmitter (idle symbol default, striping geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_tx_lanes_pkg;

    // K28.5 comma byte, sent on every lane slot that carries no data
    localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;

    // Bytes each lane carries per input word
    function automatic int bytes_per_lane(input int data_w, input int lanes);
        return data_w / (8 * lanes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_fifo
//  Description : Synchronous word FIFO with occupancy count. Push and pop in
//                the same cycle are both honoured, including when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push against a full FIFO is
    // only taken when it is paired with a pop.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/phy_tx_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_lanes
//  Description : Buffers MAC words, stripes their bytes across LANES serial
//                lanes and shifts each lane out MSB-first, one bit per clock.
//                Lanes carry IDLE_SYM whenever no word is queued.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_lanes
    import phy_tx_lanes_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter int         LANES      = 2,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEF
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [LANES-1:0]  phy_tx_out,
    output logic              tx_active,
    output logic              overflow_err
);

    localparam int                BPL       = bytes_per_lane(DATA_W, LANES);
    localparam int                SLOT_W    = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BPL - 1);
    localparam logic [DATA_W-1:0] IDLE_WORD = {(DATA_W / 8){IDLE_SYM}};

    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tx_active_q, tx_active_d;
    logic              overflow_q, overflow_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_count;

    logic              byte_end, word_end;
    logic [DATA_W-1:0] load_word;

    assign byte_end  = (bit_cnt_q == 3'd7);
    assign word_end  = byte_end && (slot_q == LAST_SLOT);
    assign ready_out = (fifo_count != CW'(FIFO_DEPTH));
    assign fifo_push = valid_in && ready_out;
    assign fifo_pop  = word_end && !fifo_empty;

    phy_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_32f),
        .reset_i (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (data_in),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Bit/slot counters, word hold register and the data/idle decision
    always_comb begin
        bit_cnt_d   = bit_cnt_q + 3'd1;
        slot_d      = slot_q;
        hold_d      = hold_q;
        tx_active_d = tx_active_q;
        overflow_d  = overflow_q | (valid_in & fifo_full);
        if (byte_end) begin
            if (slot_q == LAST_SLOT) begin
                slot_d = '0;
                if (!fifo_empty) begin
                    hold_d      = fifo_head;
                    tx_active_d = 1'b1;
                end else begin
                    // An all-idle hold word keeps later slots idle too
                    hold_d      = IDLE_WORD;
                    tx_active_d = 1'b0;
                end
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    // At a word boundary lanes take slot 0 of the new hold word; at an inner
    // byte boundary the next slot is brought to the top of the word by shifting
    assign load_word = word_end ? hold_d
                                : (hold_q << (8 * LANES * (int'(slot_q) + 1)));

    // Shared counter and status registers
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            slot_q      <= '0;
            hold_q      <= IDLE_WORD;
            tx_active_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            slot_q      <= slot_d;
            hold_q      <= hold_d;
            tx_active_q <= tx_active_d;
            overflow_q  <= overflow_d;
        end
    end

    assign tx_active    = tx_active_q;
    assign overflow_err = overflow_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] shreg_q, shreg_d;

        // Lane l owns byte (slot*LANES + l); shift out MSB-first in between
        always_comb begin
            shreg_d = {shreg_q[6:0], 1'b0};
            if (byte_end) shreg_d = load_word[DATA_W-1-8*l -: 8];
        end

        // Per-lane shift register; output bit is taken straight from the flop
        always_ff @(posedge clk_32f or posedge reset) begin
            if (reset) shreg_q <= IDLE_SYM;
            else       shreg_q <= shreg_d;
        end

        assign phy_tx_out[l] = shreg_q[7];
    end

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_tx_lanes
//  Description : Directed self-checking bench for phy_tx_lanes; a two-lane and
//                a four-lane instance share clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_tx_lanes;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data2, data4;
    logic        valid2, valid4;
    logic        ready2, ready4;
    logic [1:0]  out2;
    logic [3:0]  out4;
    logic        act2, act4;
    logic        ovf2, ovf4;

    int tests = 0;
    int fails = 0;

    logic [31:0] cap2 [2];
    logic [31:0] cap4 [4];
    int          act2_cnt, act4_cnt;
    logic [31:0] words [6];
    logic [31:0] sw    [4];

    always #5 clk = ~clk;

    phy_tx_lanes #(.DATA_W(32), .LANES(2), .FIFO_DEPTH(4), .IDLE_SYM(8'hBC)) dut2 (
        .clk_32f(clk), .reset(reset), .data_in(data2), .valid_in(valid2),
        .ready_out(ready2), .phy_tx_out(out2), .tx_active(act2), .overflow_err(ovf2)
    );

    phy_tx_lanes #(.DATA_W(32), .LANES(4), .FIFO_DEPTH(4), .IDLE_SYM(8'hBC)) dut4 (
        .clk_32f(clk), .reset(reset), .data_in(data4), .valid_in(valid4),
        .ready_out(ready4), .phy_tx_out(out4), .tx_active(act4), .overflow_err(ovf4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cap();
        for (int l = 0; l < 2; l++) cap2[l] = '0;
        for (int l = 0; l < 4; l++) cap4[l] = '0;
        act2_cnt = 0;
        act4_cnt = 0;
    endtask

    // Sample the current bit of every lane, then advance one clock
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < 2; l++) cap2[l] = {cap2[l][30:0], out2[l]};
            for (int l = 0; l < 4; l++) cap4[l] = {cap4[l][30:0], out4[l]};
            act2_cnt += int'(act2);
            act4_cnt += int'(act4);
            tick();
        end
    endtask

    // Two-lane striping: lane0 carries bytes 0,2; lane1 carries bytes 1,3
    function automatic logic [15:0] lane0_of(input logic [31:0] w);
        return {w[31:24], w[15:8]};
    endfunction
    function automatic logic [15:0] lane1_of(input logic [31:0] w);
        return {w[23:16], w[7:0]};
    endfunction

    initial begin
        words[0] = 32'h01234567; words[1] = 32'h89ABCDEF; words[2] = 32'hDEADBEEF;
        words[3] = 32'hCAFEF00D; words[4] = 32'h55555555; words[5] = 32'hAAAAAAAA;
        sw[0] = 32'h10203040; sw[1] = 32'h50607080; sw[2] = 32'h90A0B0C0; sw[3] = 32'hD0E0F001;

        reset = 1'b1; valid2 = 1'b0; valid4 = 1'b0; data2 = '0; data4 = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_out2",   out2,   2'b11);
        chk("rst_out4",   out4,   4'hF);
        chk("rst_act2",   act2,   1'b0);
        chk("rst_ready2", ready2, 1'b1);
        chk("rst_ovf2",   ovf2,   1'b0);

        // c=0: release; idle for two word periods of the 2-lane DUT
        reset = 1'b0;
        clear_cap();
        capture(16);
        chk("idle_l0",   cap2[0][15:0], 16'hBCBC);
        chk("idle_l1",   cap2[1][15:0], 16'hBCBC);
        chk("idle_act2", act2_cnt, 0);
        chk("idle4_l3",  cap4[3][15:0], 16'hBCBC);
        chk("idle_act4", act4_cnt, 0);

        // c=16: push one word into each DUT
        data2 = 32'hAABBCCDD; valid2 = 1'b1;
        data4 = 32'h11223344; valid4 = 1'b1;
        tick();
        valid2 = 1'b0; valid4 = 1'b0;
        capture(7);                       // c=17..23, pre-boundary
        clear_cap();
        capture(8);                       // c=24..31: 4-lane word
        chk("l4_lane0", cap4[0][7:0], 8'h11);
        chk("l4_lane1", cap4[1][7:0], 8'h22);
        chk("l4_lane2", cap4[2][7:0], 8'h33);
        chk("l4_lane3", cap4[3][7:0], 8'h44);
        chk("l4_act",   act4_cnt, 8);
        chk("str_pre_act2", act2_cnt, 0);
        clear_cap();
        capture(16);                      // c=32..47: 2-lane word
        chk("str_l0",  cap2[0][15:0], 16'hAACC);
        chk("str_l1",  cap2[1][15:0], 16'hBBDD);
        chk("str_act", act2_cnt, 16);
        chk("l4_post_idle", cap4[0][15:0], 16'hBCBC);
        chk("l4_post_act",  act4_cnt, 0);
        clear_cap();
        capture(16);                      // c=48..63: idle resumes
        chk("str_idle_l0",  cap2[0][15:0], 16'hBCBC);
        chk("str_idle_l1",  cap2[1][15:0], 16'hBCBC);
        chk("str_idle_act", act2_cnt, 0);

        // c=64: six back-to-back pushes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            data2 = words[i]; valid2 = 1'b1;
            if (i == 0) chk("bp_ready_first", ready2, 1'b1);
            if (i == 4) chk("bp_ready_full",  ready2, 1'b0);
            tick();
        end
        valid2 = 1'b0;
        chk("bp_ovf", ovf2, 1'b1);
        chk("bp_ovf4_clean", ovf4, 1'b0);
        capture(10);                      // c=70..79
        for (int w = 0; w < 4; w++) begin
            clear_cap();
            capture(16);                  // c=80+16w
            chk($sformatf("bp_w%0d_l0", w),  cap2[0][15:0], lane0_of(words[w]));
            chk($sformatf("bp_w%0d_l1", w),  cap2[1][15:0], lane1_of(words[w]));
            chk($sformatf("bp_w%0d_act", w), act2_cnt, 16);
        end
        chk("bp_ready_drained", ready2, 1'b1);
        clear_cap();
        capture(16);                      // c=144..159: dropped words never sent
        chk("bp_tail_l0",  cap2[0][15:0], 16'hBCBC);
        chk("bp_tail_act", act2_cnt, 0);

        // c=160: one word every 16 clocks keeps the lanes busy
        data2 = sw[0]; valid2 = 1'b1;
        tick();
        valid2 = 1'b0;
        capture(15);                      // c=161..175
        for (int k = 0; k < 4; k++) begin
            clear_cap();
            if (k < 3) begin
                data2 = sw[k+1]; valid2 = 1'b1;
            end
            capture(1);
            valid2 = 1'b0;
            capture(15);
            chk($sformatf("cs_w%0d_l0", k),  cap2[0][15:0], lane0_of(sw[k]));
            chk($sformatf("cs_w%0d_l1", k),  cap2[1][15:0], lane1_of(sw[k]));
            chk($sformatf("cs_w%0d_act", k), act2_cnt, 16);
        end

        // c=240: queue two words, then reset at bit 3 of slot 1 of the first
        data2 = 32'hF0F0F0F0; valid2 = 1'b1;
        tick();
        data2 = 32'h0F0F0F0F;
        tick();
        valid2 = 1'b0;
        repeat (25) tick();               // c=267
        reset = 1'b1;
        #1;
        chk("mr_out2",   out2,   2'b11);
        chk("mr_act2",   act2,   1'b0);
        chk("mr_ready2", ready2, 1'b1);
        chk("mr_ovf2",   ovf2,   1'b0);
        tick();
        reset = 1'b0;
        clear_cap();
        capture(32);
        chk("mr_idle_l0", cap2[0], 32'hBCBCBCBC);
        chk("mr_idle_l1", cap2[1], 32'hBCBCBCBC);
        chk("mr_idle_act", act2_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
